// File: rtl/sb_pkg.sv
// Shared types for the store buffer: default widths, FIFO entry layout, pointer sizing.
// No logic; imported by store_buffer and sb_match.
package sb_pkg;
   localparam int SB_ADDR_WIDTH = 16;
   localparam int SB_DATA_WIDTH = 16;

   typedef struct packed {
      logic                     valid;
      logic [SB_ADDR_WIDTH-1:0] addr;
      logic [SB_DATA_WIDTH-1:0] data;
   } sb_entry_t;

   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) w = i + 1;
      return w;
   endfunction
endpackage

// File: rtl/sb_match.sv
// Address compare of a load against every valid store entry; reports youngest hit.
// Purely combinational, zero latency, no flow control.
// Backpressure: none; the parent decides whether a hit stalls or forwards.
module sb_match
   import sb_pkg::*;
#(
   parameter int SB_DEPTH = 4,
   parameter int PW       = 2
) (
   input  sb_entry_t                entries [SB_DEPTH],
   input  logic [PW-1:0]            tail,
   input  logic [SB_ADDR_WIDTH-1:0] addr,
   output logic                     hit,
   output logic [PW-1:0]            hit_idx
);
   logic [PW-1:0] idx;

   // Walk oldest-to-youngest so the last assignment is the youngest match.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      idx     = '0;
      for (int k = SB_DEPTH - 1; k >= 0; k--) begin
         idx = tail - PW'(k + 1);
         if (entries[idx].valid && entries[idx].addr == addr) begin
            hit     = 1'b1;
            hit_idx = idx;
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// MEM-stage store FIFO: posts stores, drains them in order whenever no load owns the port.
// Loads respond one cycle after accept; SB_FWD_EN forwards matching stores, else the load stalls.
// Backpressure: req_ready low when full (stores), on flush, or on a store match without SB_FWD_EN.
module store_buffer
   import sb_pkg::*;
#(
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int SB_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   input  logic                  flush_req,
   output logic                  flush_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  mem_write,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   input  logic                  mem_exception,
   output logic                  sb_error
);
   localparam int PW    = clog2(SB_DEPTH);
   localparam int CNT_W = PW + 1;

   sb_entry_t        fifo_q [SB_DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic             full, hit, st_acc, ld_acc, drain;
   logic [PW-1:0]    hit_idx;

   sb_match #(.SB_DEPTH(SB_DEPTH), .PW(PW)) u_match (
      .entries (fifo_q),
      .tail    (tail_q),
      .addr    (req_addr),
      .hit     (hit),
      .hit_idx (hit_idx)
   );

   assign full       = (count_q == CNT_W'(SB_DEPTH));
   assign flush_done = flush_req && (count_q == '0);

   always_comb begin
      req_ready = 1'b0;
      if (!rst && !flush_req) begin
         if (req_write)
            req_ready = !full;
         else
`ifdef SB_FWD_EN
            req_ready = 1'b1;
`else
            req_ready = !hit;
`endif
      end
   end

   assign st_acc = req_valid && req_ready && req_write;
   assign ld_acc = req_valid && req_ready && !req_write;
   assign drain  = !rst && !ld_acc && (count_q != '0);

   // An accepted load owns the memory port; otherwise the head entry drains.
   always_comb begin
      mem_addr    = '0;
      mem_data_in = '0;
      mem_write   = 1'b0;
      if (ld_acc) begin
         mem_addr = req_addr;
      end else if (drain) begin
         mem_addr    = fifo_q[head_q].addr;
         mem_data_in = fifo_q[head_q].data;
         mem_write   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SB_DEPTH; i++) fifo_q[i] <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         sb_error  <= 1'b0;
      end else begin
         if (drain) begin
            fifo_q[head_q].valid <= 1'b0;
            head_q               <= head_q + 1'b1;
         end
         if (st_acc) begin
            fifo_q[tail_q] <= '{valid: 1'b1, addr: req_addr, data: req_wdata};
            tail_q         <= tail_q + 1'b1;
         end
         case ({st_acc, drain})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         rsp_valid <= ld_acc;
         // Without forwarding an accepted load never hits, so this mux reduces to memory data.
         if (ld_acc)
            rsp_rdata <= hit ? fifo_q[hit_idx].data : mem_data_out;
         if (mem_write && mem_exception)
            sb_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based reference model.
// Memory is a 1024-word array; addresses at or above 1024 raise mem_exception.
module tb_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_write, req_ready;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        flush_req, flush_done;
   logic [15:0] mem_addr, mem_data_in, mem_data_out;
   logic        mem_write, mem_exception, sb_error;

   store_buffer #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .SB_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_rdata     (rsp_rdata),
      .flush_req     (flush_req),
      .flush_done    (flush_done),
      .mem_addr      (mem_addr),
      .mem_data_in   (mem_data_in),
      .mem_write     (mem_write),
      .mem_data_out  (mem_data_out),
      .mem_exception (mem_exception),
      .sb_error      (sb_error)
   );

   always #5 clk = ~clk;

   // Environment memory, written only by the DUT.
   logic [15:0] env_mem [1024];
   assign mem_exception = (mem_addr >= 16'd1024);
   assign mem_data_out  = mem_exception ? 16'h0000 : env_mem[mem_addr[9:0]];
   always @(posedge clk)
      if (mem_write && !mem_exception) env_mem[mem_addr[9:0]] <= mem_data_in;

   // Reference model: pending stores in acceptance order plus expected memory image.
   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } st_t;
   st_t         sbq[$];
   logic [15:0] ref_mem [1024];
   logic        err_exp;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One request cycle: drive at negedge, check combinational outputs, advance model at posedge.
   task automatic step(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d,
                       input logic f, output logic acc);
      logic        exp_rdy, exp_mw, hit, ld_acc;
      logic [15:0] fwd_d, exp_rsp;
      @(negedge clk);
      req_valid = v;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      flush_req = f;
      #1;
      hit   = 1'b0;
      fwd_d = '0;
      foreach (sbq[i])
         if (sbq[i].addr == a) begin
            hit   = 1'b1;
            fwd_d = sbq[i].data;
         end
      if (f)       exp_rdy = 1'b0;
      else if (w)  exp_rdy = (sbq.size() < DEPTH);
      else begin
`ifdef SB_FWD_EN
         exp_rdy = 1'b1;
`else
         exp_rdy = !hit;
`endif
      end
      if (v) check("req_ready", req_ready, exp_rdy);
      ld_acc = v && !w && exp_rdy;
      exp_mw = !ld_acc && (sbq.size() > 0);
      check("mem_write", mem_write, exp_mw);
      if (ld_acc) check("load_mem_addr", mem_addr, a);
      if (exp_mw) begin
         check("drain_addr", mem_addr, sbq[0].addr);
         check("drain_data", mem_data_in, sbq[0].data);
      end
      check("flush_done", flush_done, f && (sbq.size() == 0));
      exp_rsp = hit ? fwd_d : ref_mem[a[9:0]];
      @(posedge clk);
      if (exp_mw) begin
         if (sbq[0].addr >= 16'd1024) err_exp = 1'b1;
         else ref_mem[sbq[0].addr[9:0]] = sbq[0].data;
         void'(sbq.pop_front());
      end
      if (v && w && exp_rdy) sbq.push_back('{addr: a, data: d});
      #1;
      check("rsp_valid", rsp_valid, ld_acc);
      if (ld_acc) check("rsp_rdata", rsp_rdata, exp_rsp);
      check("sb_error", sb_error, err_exp);
      acc = v && exp_rdy;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_rdata"}, rsp_rdata, 16'h0000);
      check({tag, "_mem_write"}, mem_write, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 16'h0000);
      check({tag, "_mem_data_in"}, mem_data_in, 16'h0000);
      check({tag, "_sb_error"}, sb_error, 1'b0);
   endtask

   logic [15:0] pool [4];

   initial begin
      logic acc;
      int   n;
      pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0030; pool[3] = 16'h0200;
      for (int i = 0; i < 1024; i++) begin
         env_mem[i] = 16'(i * 7 + 3);
         ref_mem[i] = 16'(i * 7 + 3);
      end
      err_exp   = 1'b0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      flush_req = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single store with idle port drains on the following cycle.
      step(1, 1, 16'h0010, 16'h1234, 0, acc);
      step(0, 0, 16'h0000, 16'h0000, 0, acc);
      step(0, 0, 16'h0000, 16'h0000, 0, acc);

      // Stores mixed with a load stream to 0x0200, then a fifth store.
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 16'(16'h0100 + i), 16'(16'hC000 + i), 0, acc);
         step(1, 0, 16'h0200, 16'h0000, 0, acc);
      end
      step(1, 0, 16'h0200, 16'h0000, 0, acc);
      step(1, 1, 16'h0104, 16'hC004, 0, acc);

      // Two stores to one address, then a load to it (forwarded or stalled).
      step(1, 1, 16'h0020, 16'hAAAA, 0, acc);
      step(1, 1, 16'h0020, 16'hBBBB, 0, acc);
      n = 0;
      do begin
         step(1, 0, 16'h0020, 16'h0000, 0, acc);
         n++;
      end while (!acc && n < 8);
      check("load_0x20_accepted", acc, 1'b1);

      // Flush with a pending store.
      step(1, 1, 16'h0030, 16'h3333, 0, acc);
      for (int i = 0; i < 4; i++) step(1, 1, 16'h0040, 16'h4444, 1, acc);
      step(0, 0, 16'h0000, 16'h0000, 0, acc);

      // Randomized traffic.
      for (int c = 0; c < 400; c++)
         step(($urandom % 4) != 0, $urandom % 2, pool[$urandom % 4], 16'($urandom),
              ($urandom % 12) == 0, acc);

      // Exception on drain is sticky.
      step(1, 1, 16'h0500, 16'hDEAD, 0, acc);
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 16'h0000, 0, acc);
      step(1, 0, 16'h0010, 16'h0000, 0, acc);

      // Reset in the middle of a drain discards pending stores.
      step(1, 1, 16'h0030, 16'h5A5A, 0, acc);
      @(negedge clk);
      req_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      sbq.delete();
      err_exp = 1'b0;
      @(posedge clk);
      #1;
      check("reset_no_write", mem_write, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0000, 16'h0000, 0, acc);
      step(1, 0, 16'h0030, 16'h0000, 0, acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
